// File: rtl/mcu_hazard_sb.sv
// Hazard, forwarding and long-latency scoreboard unit that sits beside the ID stage.
// It drives the decode stall line and the EX operand forwarding muxes, and tracks one pending bit per register.
module mcu_hazard_sb #(
  parameter int NREGS  = 32,
  parameter int NSRC   = 2,
  parameter int FWD_WB = 1,
  parameter int CNT_W  = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [RW-1:0]        id_rd,
  input  logic                 id_wr,
  input  logic                 id_long,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic                 ex_wr,
  input  logic                 ex_mem_read,
  input  logic [RW-1:0]        ex_rd,
  input  logic                 mem_valid,
  input  logic                 mem_wr,
  input  logic [RW-1:0]        mem_rd,
  input  logic                 wb_valid,
  input  logic [RW-1:0]        wb_rd,
  output logic                 stall_decode,
  output logic                 issue,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic [NREGS-1:0]     sb_pending,
  output logic [RW:0]          pending_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam bit WbFwdEn = (FWD_WB != 0);

  logic [RW-1:0]    rs;
  logic             need;
  logic [1:0]       sel;
  logic             raw_stall;
  logic             waw_stall;
  logic [NREGS-1:0] sb_next;
  logic [RW:0]      cnt_next;

  // Handshake: decode presents an instruction with id_valid; it is accepted
  // (issue=1) in the same cycle only when no stall source is active and no flush.
  always_comb begin
    rs        = '0;
    need      = 1'b0;
    sel       = 2'd0;
    raw_stall = 1'b0;
    fwd_sel   = '0;
    for (int i = 0; i < NSRC; i++) begin
      rs   = id_rs[i*RW +: RW];
      need = id_valid & id_rs_used[i] & (rs != '0);
      if (need & ex_valid & ex_mem_read & ex_wr & (ex_rd == rs))
        raw_stall = 1'b1;
      if (need & sb_pending[rs] & ~(WbFwdEn & wb_valid & (wb_rd == rs)))
        raw_stall = 1'b1;
      // Selection stays defined under a stall so the EX muxes never see X.
      if (need & ex_valid & ex_wr & ~ex_mem_read & (ex_rd == rs))
        sel = 2'd1;
      else if (need & mem_valid & mem_wr & (mem_rd == rs))
        sel = 2'd2;
      else if (need & WbFwdEn & wb_valid & (wb_rd == rs))
        sel = 2'd3;
      else
        sel = 2'd0;
      fwd_sel[i*2 +: 2] = sel;
    end
  end

  assign waw_stall    = id_valid & id_wr & (id_rd != '0) & sb_pending[id_rd]
                      & ~(wb_valid & (wb_rd == id_rd));
  assign stall_decode = raw_stall | waw_stall;
  assign issue        = id_valid & ~stall_decode & ~flush;

  // Clear first, then set, so a same-register issue keeps the bit pending.
  always_comb begin
    sb_next = sb_pending;
    if (wb_valid)
      sb_next[wb_rd] = 1'b0;
    if (issue & id_wr & id_long & (id_rd != '0))
      sb_next[id_rd] = 1'b1;
    sb_next[0] = 1'b0;
    cnt_next = '0;
    for (int k = 0; k < NREGS; k++)
      cnt_next = cnt_next + (RW+1)'(sb_next[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_pending  <= '0;
      pending_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      sb_pending  <= sb_next;
      pending_cnt <= cnt_next;
      if (stall_decode && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mcu_hazard_sb.sv
// Directed bench for mcu_hazard_sb: a FWD_WB=1 instance and a FWD_WB=0 instance
// share the same stimulus; both use a 4-bit stall counter.
module tb_mcu_hazard_sb;

  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [2*RW-1:0]   id_rs;
  logic [1:0]        id_rs_used;
  logic [RW-1:0]     id_rd;
  logic              id_wr, id_long, flush;
  logic              ex_valid, ex_wr, ex_mem_read;
  logic [RW-1:0]     ex_rd;
  logic              mem_valid, mem_wr;
  logic [RW-1:0]     mem_rd;
  logic              wb_valid;
  logic [RW-1:0]     wb_rd;

  logic              stall0, issue0, stall1, issue1;
  logic [3:0]        fwd0, fwd1;
  logic [31:0]       sb0, sb1;
  logic [RW:0]       cnt0, cnt1;
  logic [3:0]        scnt0, scnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcu_hazard_sb #(.NREGS(32), .NSRC(2), .FWD_WB(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wr(id_wr), .id_long(id_long),
    .flush(flush), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_decode(stall0), .issue(issue0),
    .fwd_sel(fwd0), .sb_pending(sb0), .pending_cnt(cnt0), .stall_cnt(scnt0)
  );

  mcu_hazard_sb #(.NREGS(32), .NSRC(2), .FWD_WB(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wr(id_wr), .id_long(id_long),
    .flush(flush), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_decode(stall1), .issue(issue1),
    .fwd_sel(fwd1), .sb_pending(sb1), .pending_cnt(cnt1), .stall_cnt(scnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wr = 0;
    id_long = 0; flush = 0; ex_valid = 0; ex_wr = 0; ex_mem_read = 0;
    ex_rd = '0; mem_valid = 0; mem_wr = 0; mem_rd = '0; wb_valid = 0; wb_rd = '0;
  endtask

  task automatic do_reset;
    set_idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    total++; if (sb0 !== 32'h0) begin bad++; $display("FAIL reset_sb got=%h exp=0", sb0); end
    total++; if (cnt0 !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    total++; if (scnt0 !== 4'd0) begin bad++; $display("FAIL reset_stallcnt got=%0d exp=0", scnt0); end
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall0); end
    total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b exp=0", issue0); end
    total++; if (fwd0 !== 4'd0) begin bad++; $display("FAIL reset_fwd got=%h exp=0", fwd0); end
  endtask

  task automatic test_load_use;
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
    #1;
    total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall0); end
    total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL lu_issue got=%b exp=0", issue0); end
    tick();
    ex_valid = 0; ex_wr = 0; ex_mem_read = 0; ex_rd = '0;
    mem_valid = 1; mem_wr = 1; mem_rd = 5'd5;
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL lu_mem_stall got=%b exp=0", stall0); end
    total++; if (fwd0[1:0] !== 2'd2) begin bad++; $display("FAIL lu_mem_fwd got=%0d exp=2", fwd0[1:0]); end
    total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL lu_mem_issue got=%b exp=1", issue0); end
    tick();
    set_idle();
  endtask

  task automatic test_long_raw;
    do_reset();
    id_valid = 1; id_wr = 1; id_long = 1; id_rd = 5'd7;
    #1;
    total++; if (issue0 !== 1'b1 || issue1 !== 1'b1) begin bad++; $display("FAIL raw_issue got=%b/%b exp=1/1", issue0, issue1); end
    tick();
    set_idle();
    #1;
    total++; if (sb0[7] !== 1'b1 || sb1[7] !== 1'b1) begin bad++; $display("FAIL raw_set got=%b/%b exp=1/1", sb0[7], sb1[7]); end
    tick();
    tick();
    id_valid = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    #1;
    total++; if (stall0 !== 1'b1 || stall1 !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b/%b exp=1/1", stall0, stall1); end
    tick();
    wb_valid = 1; wb_rd = 5'd7;
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL raw_wb_stall got=%b exp=0", stall0); end
    total++; if (fwd0[3:2] !== 2'd3) begin bad++; $display("FAIL raw_wb_fwd got=%0d exp=3", fwd0[3:2]); end
    total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL raw_wb_issue got=%b exp=1", issue0); end
    total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL raw_nofwd_stall got=%b exp=1", stall1); end
    tick();
    wb_valid = 0; wb_rd = '0;
    #1;
    total++; if (sb0[7] !== 1'b0 || sb1[7] !== 1'b0) begin bad++; $display("FAIL raw_clear got=%b/%b exp=0/0", sb0[7], sb1[7]); end
    total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL raw_nofwd_release got=%b exp=0", stall1); end
    total++; if (fwd1[3:2] !== 2'd0) begin bad++; $display("FAIL raw_nofwd_fwd got=%0d exp=0", fwd1[3:2]); end
    total++; if (issue1 !== 1'b1) begin bad++; $display("FAIL raw_nofwd_issue got=%b exp=1", issue1); end
    tick();
    set_idle();
  endtask

  task automatic test_waw;
    do_reset();
    id_valid = 1; id_wr = 1; id_long = 1; id_rd = 5'd9;
    tick();
    #1;
    total++; if (cnt0 !== 6'd1 || sb0[9] !== 1'b1) begin bad++; $display("FAIL waw_pre got=%0d/%b exp=1/1", cnt0, sb0[9]); end
    total++; if (stall0 !== 1'b1 || issue0 !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b/%b exp=1/0", stall0, issue0); end
    wb_valid = 1; wb_rd = 5'd9;
    #1;
    total++; if (stall0 !== 1'b0 || issue0 !== 1'b1) begin bad++; $display("FAIL waw_coinc got=%b/%b exp=0/1", stall0, issue0); end
    tick();
    set_idle();
    #1;
    total++; if (sb0 !== 32'h0000_0200) begin bad++; $display("FAIL waw_keep got=%h exp=00000200", sb0); end
    total++; if (cnt0 !== 6'd1) begin bad++; $display("FAIL waw_cnt got=%0d exp=1", cnt0); end
    wb_valid = 1; wb_rd = 5'd9;
    tick();
    set_idle();
    #1;
    total++; if (sb0 !== 32'h0 || cnt0 !== 6'd0) begin bad++; $display("FAIL waw_drain got=%h/%0d exp=0/0", sb0, cnt0); end
  endtask

  task automatic test_fwd_priority;
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_rd = 5'd3;
    mem_valid = 1; mem_wr = 1; mem_rd = 5'd3;
    id_valid = 1; id_rs = {5'd3, 5'd3}; id_rs_used = 2'b11;
    #1;
    total++; if (fwd0 !== 4'b0101) begin bad++; $display("FAIL pri_ex got=%b exp=0101", fwd0); end
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL pri_ex_stall got=%b exp=0", stall0); end
    ex_rd = 5'd0; mem_rd = 5'd0; id_rs = {5'd3, 5'd0};
    #1;
    total++; if (fwd0 !== 4'b0000 || stall0 !== 1'b0) begin bad++; $display("FAIL pri_r0 got=%b/%b exp=0000/0", fwd0, stall0); end
    ex_mem_read = 1;
    id_rs = {5'd0, 5'd0};
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL pri_r0_load got=%b exp=0", stall0); end
    set_idle();
    wb_valid = 1; wb_rd = 5'd6; mem_valid = 1; mem_wr = 1; mem_rd = 5'd2;
    id_valid = 1; id_rs = {5'd2, 5'd6}; id_rs_used = 2'b11;
    #1;
    total++; if (fwd0 !== 4'b1011) begin bad++; $display("FAIL pri_mem_wb got=%b exp=1011", fwd0); end
    tick();
    set_idle();
    #1;
    total++; if (sb0 !== 32'h0 || cnt0 !== 6'd0) begin bad++; $display("FAIL wb_nonpending got=%h/%0d exp=0/0", sb0, cnt0); end
  endtask

  task automatic test_flush_fill;
    do_reset();
    id_valid = 1; id_wr = 1; id_long = 1; id_rd = 5'd4; flush = 1;
    #1;
    total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL flush_issue got=%b exp=0", issue0); end
    tick();
    set_idle();
    #1;
    total++; if (sb0[4] !== 1'b0) begin bad++; $display("FAIL flush_sb got=%b exp=0", sb0[4]); end
    for (int r = 1; r < 32; r++) begin
      id_valid = 1; id_wr = 1; id_long = 1; id_rd = RW'(r);
      tick();
    end
    id_rd = 5'd0;
    tick();
    set_idle();
    #1;
    total++; if (cnt0 !== 6'd31) begin bad++; $display("FAIL fill_cnt got=%0d exp=31", cnt0); end
    total++; if (sb0 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL fill_sb got=%h exp=fffffffe", sb0); end
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    total++; if (sb0 !== 32'h0 || cnt0 !== 6'd0) begin bad++; $display("FAIL midreset got=%h/%0d exp=0/0", sb0, cnt0); end
    wb_valid = 1; wb_rd = 5'd5;
    tick();
    set_idle();
    #1;
    total++; if (sb0 !== 32'h0 || cnt0 !== 6'd0) begin bad++; $display("FAIL stale_wb got=%h/%0d exp=0/0", sb0, cnt0); end
  endtask

  task automatic test_stall_sat;
    do_reset();
    ex_valid = 1; ex_wr = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
    for (int k = 0; k < 14; k++) tick();
    total++; if (scnt0 !== 4'd14) begin bad++; $display("FAIL stallcnt_14 got=%0d exp=14", scnt0); end
    for (int k = 0; k < 6; k++) tick();
    total++; if (scnt0 !== 4'd15) begin bad++; $display("FAIL stallcnt_sat got=%0d exp=15", scnt0); end
    set_idle();
    tick();
    total++; if (scnt0 !== 4'd15) begin bad++; $display("FAIL stallcnt_hold got=%0d exp=15", scnt0); end
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_long_raw();
    test_waw();
    test_fwd_priority();
    test_flush_fill();
    test_stall_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcu_hazard_sb.md
# mcu_hazard_sb

Parametrised hazard, forwarding and scoreboard unit for the control-processor pipeline. It handles load-use stalls, per-operand forwarding selection, and long-latency results (multi-cycle mul/div, uncached loads) that retire out of band through a dedicated writeback port. A per-register scoreboard blocks dependent and WAW instructions in decode until the pending result returns. Sits beside the ID stage; its outputs drive the decode stall line and the EX-stage operand muxes.

## Interface
- NREGS, 32, architectural integer registers (power of two, ≥ 2); RW = $clog2(NREGS)
- NSRC, 2, source operands per instruction (1–3)
- FWD_WB, 1, 1 = same-cycle bypass from the long-latency writeback port; 0 = stall until the scoreboard clears
- CNT_W, 32, stall counter width

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  instruction present in decode
- id_rs  in  NSRC*RW  source register indices, operand i at [i*RW +: RW]
- id_rs_used  in  NSRC  operand i is read
- id_rd  in  RW  destination index
- id_wr  in  1  instruction writes id_rd
- id_long  in  1  destination is produced by the long-latency path
- flush  in  1  kill the decode instruction this cycle (no issue)
- ex_valid, ex_wr, ex_mem_read  in  1 each  EX-stage state
- ex_rd  in  RW  EX destination
- mem_valid, mem_wr  in  1 each  MEM-stage state
- mem_rd  in  RW  MEM destination
- wb_valid  in  1  long-latency result written this cycle
- wb_rd  in  RW  its destination
- stall_decode  out  1  hold IF/ID, insert bubble into EX
- issue  out  1  id_valid & ~stall_decode & ~flush
- fwd_sel  out  NSRC*2  per operand: 0 regfile, 1 EX, 2 MEM, 3 long WB
- sb_pending  out  NREGS  scoreboard bit vector
- pending_cnt  out  RW+1  number of set scoreboard bits
- stall_cnt  out  CNT_W  saturating count of cycles with stall_decode=1

## Operation
- Register 0 never matches. A match on rd=0 never stalls or forwards, and bit 0 is never set.
- Operand i "needs" register r when id_valid & id_rs_used[i] & id_rs[i]==r & r!=0.
- Stall sources (OR-ed):
  - load-use: ex_valid & ex_mem_read & ex_wr & ex_rd==needed rs
  - RAW long: sb_pending[rs] and not (FWD_WB & wb_valid & wb_rd==rs)
  - WAW long: id_valid & id_wr & id_rd!=0 & sb_pending[id_rd] & ~(wb_valid & wb_rd==id_rd)
- Forward priority per operand: EX (ex_valid & ex_wr & ~ex_mem_read) > MEM (mem_valid & mem_wr) > long WB (FWD_WB & wb_valid) > regfile.
- fwd_sel is don't-care while stalled, but must be deterministic: same rules, no X.
- Scoreboard next state:
  - clear bit wb_rd when wb_valid
  - then set bit id_rd when issue & id_wr & id_long & id_rd!=0
  - set wins on same-register coincidence
- wb_valid to a non-pending register is ignored (no underflow).
- flush suppresses issue, so no scoreboard set. Long ops already issued still complete and clear normally.
- pending_cnt is the registered popcount of the next state, so it equals popcount(sb_pending) every cycle.
- stall_cnt increments when stall_decode=1 and holds at all-ones.

## Timing
- stall_decode, issue, fwd_sel: combinational from current inputs and registered scoreboard; zero-cycle latency.
- Scoreboard set/clear is visible on sb_pending the cycle after the issue/wb edge.
- Reset (rst_n=0 at an edge): sb_pending=0, pending_cnt=0, stall_cnt=0. Combinational outputs follow: with id_valid=0, stall_decode=0, issue=0, fwd_sel=0.
- Reset mid-operation discards all pending entries. Later wb_valid pulses for those entries are ignored.
- Full scoreboard (NREGS-1 bits set) is legal: pending_cnt = NREGS-1, no wrap.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5; decode rs1=5 -> stall_decode=1 for 1 cycle. Next cycle, with the load in MEM: stall_decode=0, fwd_sel[0]=2.
- Long RAW with FWD_WB=1: issue long rd=7; 3 cycles later decode rs2=7 -> stall_decode=1 until wb_valid, wb_rd=7. That cycle: stall_decode=0, fwd_sel[1]=3, sb_pending[7] clears next cycle.
- Same with FWD_WB=0 -> one extra stall cycle, then fwd_sel=0.
- WAW plus same-cycle clear: reg 9 pending. Decode long write rd=9 with wb_valid, wb_rd=9 -> issue=1, sb_pending[9] stays 1, pending_cnt unchanged.
- Forward priority: EX and MEM both write rd=3, rs1=3 -> fwd_sel[0]=1. rd=0 in EX with rs1=0 -> fwd_sel[0]=0, no stall.
- Flush/reset: issue long rd=4 with flush=1 -> sb_pending[4]=0. Fill regs 1..31 -> pending_cnt=31. Assert rst_n=0 -> all zero next cycle. Hold stall 2^CNT_W cycles (CNT_W=4 build) -> stall_cnt saturates at 15.
